// File: rtl/mem_dump_reader_pkg.sv
// Shared types and constants for the memory-dump reader and other memory-controller clients.
package mem_dump_reader_pkg;
   localparam int MEM_ADDR_W = 26;
   localparam int WIN_W      = 12;

   typedef enum logic [2:0] {IDLE, REQ, ACK, DATA, EMIT, CSUM, FIN} dump_state_t;

   typedef struct packed {
      logic                  read;
      logic [MEM_ADDR_W-1:0] address;
   } mem_req_t;
endpackage

// File: rtl/mem_dump_reader_timer.sv
// mem_req_timer: loadable down-counter with expire flag for bounding memory-controller waits.
module mem_req_timer
   import mem_dump_reader_pkg::*;
#(
   parameter int TO_W = 10
) (
   input  logic            clk_100mhz,
   input  logic            rst,
   input  logic            load,
   input  logic [TO_W-1:0] load_val,
   input  logic            en,
   output logic            expired
);
   logic [TO_W-1:0] cnt;

   always_ff @(posedge clk_100mhz or posedge rst) begin
      if (rst)                     cnt <= '0;
      else if (load)               cnt <= load_val;
      else if (en && cnt != '0)    cnt <= cnt - 1'b1;
   end

   assign expired = (cnt == '0);
endmodule

// File: rtl/mem_dump_reader.sv
// Walks a word window over the memory controller and streams each low byte on a valid/ready port.
// Define CHECKSUM_EN to append an 8-bit sum byte after the data bytes.
module mem_dump_reader
   import mem_dump_reader_pkg::*;
#(
   parameter int ADDR_W  = WIN_W,
   parameter int TIMEOUT = 1023,
   parameter int TO_W    = 10
) (
   input  logic                  clk_100mhz,
   input  logic                  rst,
   input  logic                  start,
   input  logic [ADDR_W-1:0]     base_addr,
   input  logic [ADDR_W:0]       length,
   output logic                  mem_read,
   output logic [MEM_ADDR_W-1:0] mem_address,
   input  logic [15:0]           mem_read_data,
   input  logic                  mem_busy,
   output logic [7:0]            byte_out,
   output logic                  byte_valid,
   input  logic                  byte_ready,
   output logic                  busy,
   output logic                  done,
   output logic                  error
);
   // Load value chosen so done lands TIMEOUT cycles after a stalled request pulse.
   localparam logic [TO_W-1:0] TO_LOAD = TO_W'(TIMEOUT - 2);

   dump_state_t       state, state_d;
   mem_req_t          req, req_d;
   logic [7:0]        byte_out_d;
   logic              byte_valid_d, busy_d, done_d, error_d;
   logic [ADDR_W:0]   idx, idx_d, len_q, len_d;
   logic [ADDR_W-1:0] base_q, base_d, win_addr;
   logic              tmr_load, tmr_en, tmr_expired;
   logic              unused_hi;
`ifdef CHECKSUM_EN
   logic [7:0]        csum, csum_d;
`endif

   assign win_addr    = base_q + idx[ADDR_W-1:0];
   assign mem_read    = req.read;
   assign mem_address = req.address;
   assign unused_hi   = &{1'b0, mem_read_data[15:8]};

   assign tmr_en   = (state == REQ) || (state == ACK) || (state == DATA);
   assign tmr_load = (state_d != state) &&
                     ((state_d == REQ) || (state_d == ACK) || (state_d == DATA));

   mem_req_timer #(.TO_W(TO_W)) u_timer (
      .clk_100mhz (clk_100mhz),
      .rst        (rst),
      .load       (tmr_load),
      .load_val   (TO_LOAD),
      .en         (tmr_en),
      .expired    (tmr_expired)
   );

   always_comb begin
      state_d      = state;
      req_d        = req;
      req_d.read   = 1'b0;
      byte_out_d   = byte_out;
      byte_valid_d = byte_valid;
      busy_d       = busy;
      done_d       = 1'b0;
      error_d      = error;
      idx_d        = idx;
      base_d       = base_q;
      len_d        = len_q;
`ifdef CHECKSUM_EN
      csum_d       = csum;
`endif
      case (state)
         // The done cycle is already IDLE, so a start landing on it is dropped here.
         IDLE: if (start && !done) begin
            base_d  = base_addr;
            len_d   = length;
            idx_d   = '0;
            busy_d  = 1'b1;
            error_d = 1'b0;
`ifdef CHECKSUM_EN
            csum_d  = 8'h00;
            if (length == '0) begin
               state_d      = CSUM;
               byte_out_d   = 8'h00;
               byte_valid_d = 1'b1;
            end else state_d = REQ;
`else
            state_d = (length == '0) ? FIN : REQ;
`endif
         end
         REQ: begin
            if (tmr_expired) begin
               error_d = 1'b1;
               state_d = FIN;
            end else if (!mem_busy) begin
               req_d.read    = 1'b1;
               req_d.address = {{(MEM_ADDR_W-ADDR_W){1'b0}}, win_addr};
               state_d       = ACK;
            end
         end
         ACK: begin
            if (tmr_expired) begin
               error_d = 1'b1;
               state_d = FIN;
            end else if (mem_busy) state_d = DATA;
         end
         DATA: begin
            if (tmr_expired) begin
               error_d = 1'b1;
               state_d = FIN;
            end else if (!mem_busy) begin
               byte_out_d   = mem_read_data[7:0];
               byte_valid_d = 1'b1;
               state_d      = EMIT;
            end
         end
         EMIT: if (byte_ready) begin
            byte_valid_d = 1'b0;
            idx_d        = idx + 1'b1;
`ifdef CHECKSUM_EN
            csum_d       = csum + byte_out;
`endif
            if (idx_d == len_q) begin
`ifdef CHECKSUM_EN
               state_d      = CSUM;
               byte_out_d   = csum_d;
               byte_valid_d = 1'b1;
`else
               state_d      = FIN;
`endif
            end else state_d = REQ;
         end
`ifdef CHECKSUM_EN
         CSUM: if (byte_ready) begin
            byte_valid_d = 1'b0;
            state_d      = FIN;
         end
`endif
         FIN: begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_100mhz or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         req        <= '0;
         byte_out   <= '0;
         byte_valid <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         error      <= 1'b0;
         idx        <= '0;
         base_q     <= '0;
         len_q      <= '0;
      end else begin
         state      <= state_d;
         req        <= req_d;
         byte_out   <= byte_out_d;
         byte_valid <= byte_valid_d;
         busy       <= busy_d;
         done       <= done_d;
         error      <= error_d;
         idx        <= idx_d;
         base_q     <= base_d;
         len_q      <= len_d;
      end
   end

`ifdef CHECKSUM_EN
   always_ff @(posedge clk_100mhz or posedge rst) begin
      if (rst) csum <= '0;
      else     csum <= csum_d;
   end
`endif
endmodule
